// File: rtl/ramio_arbiter_if.sv
// ramio_arbiter_if
//   Bundles the requester-side handshake and the RAMIO command port of
//   ramio_arbiter. Port i of each packed request field sits at
//   [W*i +: W] (W = 1, 2, 3, 32, 32 for valid, write_type, read_type,
//   address, data_in).
//   slave  : the arbiter (consumes requests and RAMIO status, drives
//            grants/responses and the RAMIO command)
//   master : the environment (requesters plus the RAMIO block)
interface ramio_arbiter_if #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned IX_BITWIDTH = $clog2(NUM_PORTS > 1 ? NUM_PORTS : 2)
);
    logic [NUM_PORTS-1:0]    req_valid;
    logic [2*NUM_PORTS-1:0]  req_write_type;
    logic [3*NUM_PORTS-1:0]  req_read_type;
    logic [32*NUM_PORTS-1:0] req_address;
    logic [32*NUM_PORTS-1:0] req_data_in;
    logic [NUM_PORTS-1:0]    req_grant;
    logic [NUM_PORTS-1:0]    rsp_done;
    logic [NUM_PORTS-1:0]    rsp_error;
    logic [31:0]             rsp_data;
    logic [IX_BITWIDTH-1:0]  owner;
    logic                    active;
    logic                    ramio_enable;
    logic [1:0]              ramio_write_type;
    logic [2:0]              ramio_read_type;
    logic [31:0]             ramio_address;
    logic [31:0]             ramio_data_in;
    logic [31:0]             ramio_data_out;
    logic                    ramio_data_out_ready;
    logic                    ramio_busy;

    modport slave (
        input  req_valid, req_write_type, req_read_type, req_address, req_data_in,
        input  ramio_data_out, ramio_data_out_ready, ramio_busy,
        output req_grant, rsp_done, rsp_error, rsp_data, owner, active,
        output ramio_enable, ramio_write_type, ramio_read_type,
        output ramio_address, ramio_data_in
    );

    modport master (
        output req_valid, req_write_type, req_read_type, req_address, req_data_in,
        output ramio_data_out, ramio_data_out_ready, ramio_busy,
        input  req_grant, rsp_done, rsp_error, rsp_data, owner, active,
        input  ramio_enable, ramio_write_type, ramio_read_type,
        input  ramio_address, ramio_data_in
    );
endinterface

// File: rtl/ramio_arbiter.sv
// ramio_arbiter
//   Shares one RAMIO command port among NUM_PORTS requesters using a
//   valid/grant/done handshake, with round-robin (PRIORITY_MODE=0) or
//   lowest-index-wins (PRIORITY_MODE=1) arbitration and a WAIT timeout
//   (TIMEOUT_CYCLES, 0 = never) that completes the transaction with an error.
//   clk   : br_clk_out domain clock
//   rst_n : asynchronous active-low reset
//   bus   : ramio_arbiter_if.slave -- requests, grant/done/error pulses,
//           rsp_data, owner, active, and the RAMIO command/status signals.
//   All outputs are registered.
module ramio_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned IX_BITWIDTH    = $clog2(NUM_PORTS > 1 ? NUM_PORTS : 2)
) (
    input logic            clk,
    input logic            rst_n,
    ramio_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [IX_BITWIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cmd_write_q, cmd_write_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   done_q, done_d;
    logic [NUM_PORTS-1:0]   error_q, error_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic [IX_BITWIDTH-1:0] owner_q, owner_d;
    logic                   active_q, active_d;
    logic                   en_q, en_d;
    logic [1:0]             wt_q, wt_d;
    logic [2:0]             rt_q, rt_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            din_q, din_d;

    logic                   found;
    logic [IX_BITWIDTH-1:0] win;
    int                     rank, best_rank;
    logic [1:0]             wt_sel;
    logic [2:0]             rt_sel;
    logic [31:0]            addr_sel, din_sel;

    // Winner selection: each valid port gets a rank (distance after the rr
    // pointer, or its own index in fixed mode); the lowest rank wins.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        rank      = 0;
        best_rank = int'(NUM_PORTS);
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (PRIORITY_MODE == 1) begin
                rank = int'(i);
            end else begin
                rank = int'(i) + int'(NUM_PORTS) - 1 - int'(ptr_q);
                if (rank >= int'(NUM_PORTS)) rank = rank - int'(NUM_PORTS);
            end
            if (bus.req_valid[i[IX_BITWIDTH-1:0]] && (rank < best_rank)) begin
                found     = 1'b1;
                win       = i[IX_BITWIDTH-1:0];
                best_rank = rank;
            end
        end
    end

    always_comb begin
        wt_sel   = '0;
        rt_sel   = '0;
        addr_sel = '0;
        din_sel  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (win == i[IX_BITWIDTH-1:0]) begin
                wt_sel   = bus.req_write_type[2*i +: 2];
                rt_sel   = bus.req_read_type[3*i +: 3];
                addr_sel = bus.req_address[32*i +: 32];
                din_sel  = bus.req_data_in[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        cmd_write_d = cmd_write_q;
        grant_d     = '0;
        done_d      = '0;
        error_d     = '0;
        rsp_data_d  = rsp_data_q;
        owner_d     = owner_q;
        active_d    = active_q;
        en_d        = 1'b0;
        wt_d        = '0;
        rt_d        = '0;
        addr_d      = '0;
        din_d       = '0;
        case (state_q)
            S_IDLE: begin
                if (!bus.ramio_busy && found) begin
                    grant_d[win] = 1'b1;
                    owner_d      = win;
                    if (PRIORITY_MODE == 0) ptr_d = win;
                    if ((wt_sel == '0) && (rt_sel == '0)) begin
                        // No-op completes with the grant; RAMIO is not touched.
                        done_d[win] = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        active_d    = 1'b1;
                        state_d     = S_ISSUE;
                        en_d        = 1'b1;
                        cmd_write_d = (wt_sel != '0);
                        wt_d        = wt_sel;
                        rt_d        = (wt_sel != '0) ? '0 : rt_sel;
                        addr_d      = addr_sel;
                        din_d       = (wt_sel != '0) ? din_sel : '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (!bus.ramio_busy && (cmd_write_q || bus.ramio_data_out_ready)) begin
                    done_d[owner_q] = 1'b1;
                    rsp_data_d      = cmd_write_q ? '0 : bus.ramio_data_out;
                    active_d        = 1'b0;
                    state_d         = S_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    done_d[owner_q]  = 1'b1;
                    error_d[owner_q] = 1'b1;
                    rsp_data_d       = '0;
                    active_d         = 1'b0;
                    state_d          = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= IX_BITWIDTH'(NUM_PORTS - 1);
            cnt_q       <= '0;
            cmd_write_q <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
            error_q     <= '0;
            rsp_data_q  <= '0;
            owner_q     <= '0;
            active_q    <= 1'b0;
            en_q        <= 1'b0;
            wt_q        <= '0;
            rt_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            cmd_write_q <= cmd_write_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rsp_data_q  <= rsp_data_d;
            owner_q     <= owner_d;
            active_q    <= active_d;
            en_q        <= en_d;
            wt_q        <= wt_d;
            rt_q        <= rt_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign bus.req_grant        = grant_q;
    assign bus.rsp_done         = done_q;
    assign bus.rsp_error        = error_q;
    assign bus.rsp_data         = rsp_data_q;
    assign bus.owner            = owner_q;
    assign bus.active           = active_q;
    assign bus.ramio_enable     = en_q;
    assign bus.ramio_write_type = wt_q;
    assign bus.ramio_read_type  = rt_q;
    assign bus.ramio_address    = addr_q;
    assign bus.ramio_data_in    = din_q;
endmodule

// File: tb/tb_ramio_arbiter.sv
// tb_ramio_arbiter
//   Bench for ramio_arbiter: a round-robin instance (with a RAMIO model that
//   answers reads after a programmable latency, or sticks busy) and a
//   fixed-priority instance (with a one-cycle-busy write model).
module tb_ramio_arbiter;
    localparam int unsigned NP = 2;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ramio_arbiter_if #(.NUM_PORTS(NP)) a_if ();
    ramio_arbiter_if #(.NUM_PORTS(NP)) b_if ();

    ramio_arbiter #(.NUM_PORTS(NP), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(a_if));
    ramio_arbiter #(.NUM_PORTS(NP), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(b_if));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // RAMIO model for dut_rr: read data = DEADBEEF ^ (address - 0x100)
    logic        m_rd;
    int          m_cnt;
    int          m_lat = 5;
    bit          m_stuck = 1'b0;
    logic [31:0] m_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_if.ramio_busy           <= 1'b0;
            a_if.ramio_data_out_ready <= 1'b0;
            a_if.ramio_data_out       <= '0;
            m_rd <= 1'b0; m_cnt <= 0; m_addr <= '0;
        end else begin
            a_if.ramio_data_out_ready <= 1'b0;
            if (a_if.ramio_enable) begin
                a_if.ramio_busy <= 1'b1;
                m_cnt  <= m_lat;
                m_rd   <= (a_if.ramio_read_type != 3'd0);
                m_addr <= a_if.ramio_address;
            end else if (a_if.ramio_busy) begin
                if (m_cnt > 1) m_cnt <= m_cnt - 1;
                else if (!m_stuck) begin
                    a_if.ramio_busy           <= 1'b0;
                    a_if.ramio_data_out_ready <= m_rd;
                    a_if.ramio_data_out       <= m_rd ? (32'hDEAD_BEEF ^ (m_addr - 32'h100)) : '0;
                end
            end
        end
    end

    // RAMIO model for dut_fp: busy for the single cycle after enable
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_if.ramio_busy <= 1'b0;
        else        b_if.ramio_busy <= b_if.ramio_enable;
    end
    assign b_if.ramio_data_out       = '0;
    assign b_if.ramio_data_out_ready = 1'b0;

    typedef struct {
        int port; logic [31:0] data; bit chk_data; bit err; bit noop;
    } exp_t;
    typedef struct packed {
        logic [1:0] wt; logic [2:0] rt; logic [31:0] addr; logic [31:0] din;
    } iss_t;
    typedef struct {
        int port; logic [1:0] wt; logic [2:0] rt; logic [31:0] addr; logic [31:0] din;
        bit issue; logic [1:0] e_wt; logic [2:0] e_rt; logic [31:0] e_din;
        bit chk_data; logic [31:0] e_data;
    } vec_t;

    exp_t exp_q[$];
    iss_t iss_q[$];
    int   grant_log[$];
    int   done_seen = 0, en_seen = 0, cyc = 0;
    int   last_grant_cyc = 0, last_done_cyc = 0;
    bit   in_flight = 1'b0;
    exp_t e_cur;
    iss_t i_cur;
    logic [NP-1:0] oh;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor for dut_rr, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (|a_if.req_grant) begin
                chk("grant_no_overlap", {127'd0, in_flight}, 128'd0);
                for (int p = 0; p < NP; p++)
                    if (a_if.req_grant[p]) begin
                        grant_log.push_back(p);
                        chk("owner_at_grant", a_if.owner, p);
                    end
                last_grant_cyc = cyc;
                if (!(|a_if.rsp_done)) begin
                    in_flight = 1'b1;
                    chk("active_at_grant", a_if.active, 1);
                end
            end
            if (a_if.ramio_enable) begin
                en_seen++;
                if (iss_q.size() == 0) chk("unexpected_enable", a_if.ramio_enable, 0);
                else begin
                    i_cur = iss_q.pop_front();
                    chk("issue_cmd", {a_if.ramio_write_type, a_if.ramio_read_type,
                                      a_if.ramio_address, a_if.ramio_data_in}, i_cur);
                end
            end
            if (|(a_if.rsp_error & ~a_if.rsp_done))
                chk("error_without_done", a_if.rsp_error & ~a_if.rsp_done, 0);
            if (|a_if.rsp_done) begin
                done_seen++;
                last_done_cyc = cyc;
                in_flight = 1'b0;
                if (exp_q.size() == 0) chk("unexpected_done", a_if.rsp_done, 0);
                else begin
                    e_cur = exp_q.pop_front();
                    oh = '0;
                    oh[e_cur.port] = 1'b1;
                    chk("done_port", a_if.rsp_done, oh);
                    chk("error_flag", a_if.rsp_error, e_cur.err ? oh : '0);
                    if (e_cur.chk_data) chk("rsp_data", a_if.rsp_data, e_cur.data);
                    if (e_cur.noop) chk("noop_grant_with_done", a_if.req_grant, oh);
                end
            end
        end
    end

    task automatic set_port(input int p, input logic [1:0] wt, input logic [2:0] rt,
                            input logic [31:0] addr, input logic [31:0] din);
        a_if.req_write_type[2*p +: 2] = wt;
        a_if.req_read_type[3*p +: 3]  = rt;
        a_if.req_address[32*p +: 32]  = addr;
        a_if.req_data_in[32*p +: 32]  = din;
        a_if.req_valid[p]             = 1'b1;
    endtask

    task automatic push_exp(input int p, input logic [31:0] d, input bit cd, input bit err, input bit noop);
        exp_t e;
        e.port = p; e.data = d; e.chk_data = cd; e.err = err; e.noop = noop;
        exp_q.push_back(e);
    endtask

    task automatic push_iss(input logic [1:0] wt, input logic [2:0] rt,
                            input logic [31:0] addr, input logic [31:0] din);
        iss_q.push_back({wt, rt, addr, din});
    endtask

    task automatic start_txn(input vec_t v, input bit err);
        @(negedge clk);
        set_port(v.port, v.wt, v.rt, v.addr, v.din);
        push_exp(v.port, v.e_data, v.chk_data, err, !v.issue);
        if (v.issue) push_iss(v.e_wt, v.e_rt, v.addr, v.e_din);
    endtask

    task automatic wait_grant_drop(input int p, input int bound);
        int c = 0;
        while (!a_if.req_grant[p] && c < bound) begin @(negedge clk); c++; end
        chk("grant_wait", a_if.req_grant[p], 1);
        a_if.req_valid[p] = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        int c = 0;
        while (done_seen < target && c < bound) begin @(negedge clk); c++; end
        chk("done_wait", done_seen >= target, 1);
    endtask

    // Drives until n grants have been seen; either drops each port as it is
    // granted, or keeps every port valid until the n-th grant.
    task automatic run_multi(input int n, input bit drop_each, input int bound);
        int g = 0;
        int target = done_seen + n;
        for (int c = 0; c < bound && done_seen < target; c++) begin
            @(negedge clk);
            if (|a_if.req_grant) begin
                g++;
                for (int p = 0; p < NP; p++)
                    if (a_if.req_grant[p] && drop_each) a_if.req_valid[p] = 1'b0;
                if (g >= n) a_if.req_valid = '0;
            end
        end
        chk("multi_done_wait", done_seen >= target, 1);
    endtask

    vec_t vecs[6];
    vec_t tv;
    int   target, en_before, gsz, c;

    initial begin
        vecs[0] = '{0, 2'd0, 3'd2, 32'h100, 32'h55,        1, 2'd0, 3'd2, 32'h0,        1, 32'hDEAD_BEEF};
        vecs[1] = '{1, 2'd1, 3'd4, 32'h200, 32'hCAFE_0001, 1, 2'd1, 3'd0, 32'hCAFE_0001, 0, 32'h0};
        vecs[2] = '{1, 2'd0, 3'd0, 32'h300, 32'h77,        0, 2'd0, 3'd0, 32'h0,        1, 32'h0};
        vecs[3] = '{0, 2'd0, 3'd1, 32'h104, 32'h0,         1, 2'd0, 3'd1, 32'h0,        1, 32'hDEAD_BEEB};
        vecs[4] = '{0, 2'd3, 3'd0, 32'h10,  32'hFFFF_FFFF, 1, 2'd3, 3'd0, 32'hFFFF_FFFF, 0, 32'h0};
        vecs[5] = '{1, 2'd0, 3'd7, 32'h1FC, 32'h1234_5678, 1, 2'd0, 3'd7, 32'h0,        1, 32'hDEAD_BE13};

        a_if.req_valid = '0; a_if.req_write_type = '0; a_if.req_read_type = '0;
        a_if.req_address = '0; a_if.req_data_in = '0;
        b_if.req_valid = '0; b_if.req_write_type = '0; b_if.req_read_type = '0;
        b_if.req_address = '0; b_if.req_data_in = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {a_if.req_grant, a_if.rsp_done, a_if.rsp_error, a_if.rsp_data,
                              a_if.owner, a_if.active, a_if.ramio_enable, a_if.ramio_write_type,
                              a_if.ramio_read_type, a_if.ramio_address, a_if.ramio_data_in}, 0);
        rst_n = 1'b1;

        // Table: single transactions, one at a time
        for (int k = 0; k < 6; k++) begin
            en_before = en_seen;
            target = done_seen + 1;
            start_txn(vecs[k], 1'b0);
            wait_grant_drop(vecs[k].port, 40);
            wait_done(target, 60);
            chk("enable_pulses", en_seen - en_before, vecs[k].issue ? 1 : 0);
        end

        // Round-robin: both ports held valid for four transactions
        grant_log.delete();
        @(negedge clk);
        set_port(0, 2'd0, 3'd1, 32'h100, 32'h0);
        set_port(1, 2'd0, 3'd1, 32'h108, 32'h0);
        for (int k = 0; k < 4; k++) begin
            push_exp(k % 2, (k % 2 == 0) ? 32'hDEAD_BEEF : 32'hDEAD_BEE7, 1, 0, 0);
            push_iss(2'd0, 3'd1, (k % 2 == 0) ? 32'h100 : 32'h108, 32'h0);
        end
        run_multi(4, 1'b0, 200);
        chk("rr_grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            chk("rr_grant_order", grant_log[k], k % 2);

        // Timeout with RAMIO busy stuck, then no reissue until busy drops
        m_stuck = 1'b1;
        tv = '{0, 2'd1, 3'd0, 32'h400, 32'h1, 1, 2'd1, 3'd0, 32'h1, 1, 32'h0};
        target = done_seen + 1;
        start_txn(tv, 1'b1);
        wait_grant_drop(0, 40);
        wait_done(target, 60);
        chk("timeout_latency", last_done_cyc - last_grant_cyc, TO + 1);
        tv = '{0, 2'd0, 3'd1, 32'h100, 32'h0, 1, 2'd0, 3'd1, 32'h0, 1, 32'hDEAD_BEEF};
        target = done_seen + 1;
        start_txn(tv, 1'b0);
        gsz = grant_log.size();
        repeat (10) @(negedge clk);
        chk("no_reissue_while_busy", grant_log.size() - gsz, 0);
        m_stuck = 1'b0;
        wait_grant_drop(0, 40);
        wait_done(target, 60);

        // Reset during WAIT aborts silently; port 0 wins first afterwards
        tv = '{0, 2'd0, 3'd1, 32'h100, 32'h0, 1, 2'd0, 3'd1, 32'h0, 1, 32'hDEAD_BEEF};
        start_txn(tv, 1'b0);
        wait_grant_drop(0, 40);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_wait", {a_if.req_grant, a_if.rsp_done, a_if.rsp_error, a_if.rsp_data,
                               a_if.owner, a_if.active, a_if.ramio_enable, a_if.ramio_write_type,
                               a_if.ramio_read_type, a_if.ramio_address, a_if.ramio_data_in}, 0);
        exp_q.delete();
        iss_q.delete();
        in_flight = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        grant_log.delete();
        set_port(0, 2'd0, 3'd1, 32'h108, 32'h0);
        set_port(1, 2'd0, 3'd1, 32'h100, 32'h0);
        push_exp(0, 32'hDEAD_BEE7, 1, 0, 0); push_iss(2'd0, 3'd1, 32'h108, 32'h0);
        push_exp(1, 32'hDEAD_BEEF, 1, 0, 0); push_iss(2'd0, 3'd1, 32'h100, 32'h0);
        run_multi(2, 1'b1, 100);
        chk("first_after_reset", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // Fixed priority: port 0 re-requests after every done
        @(negedge clk);
        b_if.req_write_type = {2'd1, 2'd1};
        b_if.req_address    = {32'h20, 32'h10};
        b_if.req_valid      = 2'b11;
        for (int k = 0; k < 4; k++) begin
            c = 0;
            do begin @(negedge clk); c++; end while (!(|b_if.req_grant) && c < 20);
            chk("fp_grant", b_if.req_grant, (k < 3) ? 2'b01 : 2'b10);
            b_if.req_valid = b_if.req_valid & ~b_if.req_grant;
            c = 0;
            while (!(|b_if.rsp_done) && c < 20) begin @(negedge clk); c++; end
            chk("fp_done", b_if.rsp_done, (k < 3) ? 2'b01 : 2'b10);
            if (k < 2) b_if.req_valid[0] = 1'b1;
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + iss_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
